// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops, shift-add MULU and optional restoring DIVU.
// Define MULTICYCLE_ALU_DIV_EN to build the divider; otherwise op 111 completes at once with zeros.
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             equal,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_MULU = 3'b110;
  localparam logic [2:0] OP_DIVU = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [CW-1:0]    count_q, count_d;
  logic             eq_pend_q, eq_pend_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             equal_q, equal_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   mul_sum;

  function automatic logic [WIDTH-1:0] alu_fn(input logic [2:0] f,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (f)
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      OP_NOR:  r = ~(x | y);
      default: r = {WIDTH{1'b0}};
    endcase
    alu_fn = r;
  endfunction

  // Multiplier step: conditionally add multiplicand into the high half, then shift right.
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});

`ifdef MULTICYCLE_ALU_DIV_EN
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] div_diff;
  logic           q_bit;
  // Divider step: remainder < divisor, so rem_sh fits WIDTH+1 bits and diff[WIDTH] is the sign.
  assign rem_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_diff = rem_sh - {1'b0, mcand_q};
  assign q_bit    = ~div_diff[WIDTH];
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    count_d   = count_q;
    eq_pend_d = eq_pend_q;
    result_d  = result_q;
    hi_d      = hi_q;
    equal_d   = equal_q;
    dz_d      = dz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MULU) begin
            state_d   = S_MUL;
            mcand_d   = a;
            acc_hi_d  = {WIDTH{1'b0}};
            acc_lo_d  = b;
            count_d   = {CW{1'b0}};
            eq_pend_d = (a == b);
          end else if (op == OP_DIVU) begin
`ifdef MULTICYCLE_ALU_DIV_EN
            if (b == {WIDTH{1'b0}}) begin
              state_d  = S_DONE;
              result_d = {WIDTH{1'b1}};
              hi_d     = a;
              equal_d  = (a == b);
              dz_d     = 1'b1;
            end else begin
              state_d   = S_DIV;
              mcand_d   = b;
              acc_hi_d  = {WIDTH{1'b0}};
              acc_lo_d  = a;
              count_d   = {CW{1'b0}};
              eq_pend_d = (a == b);
            end
`else
            state_d  = S_DONE;
            result_d = {WIDTH{1'b0}};
            hi_d     = {WIDTH{1'b0}};
            equal_d  = (a == b);
            dz_d     = 1'b0;
`endif
          end else begin
            state_d  = S_DONE;
            result_d = alu_fn(op, a, b);
            hi_d     = {WIDTH{1'b0}};
            equal_d  = (a == b);
            dz_d     = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        acc_hi_d = mul_sum[WIDTH:1];
        acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        if (count_q == CNT_LAST) begin
          state_d  = S_DONE;
          result_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
          hi_d     = mul_sum[WIDTH:1];
          equal_d  = eq_pend_q;
          dz_d     = 1'b0;
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end
`ifdef MULTICYCLE_ALU_DIV_EN
      S_DIV: begin
        acc_hi_d = q_bit ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        acc_lo_d = {acc_lo_q[WIDTH-2:0], q_bit};
        if (count_q == CNT_LAST) begin
          state_d  = S_DONE;
          result_d = {acc_lo_q[WIDTH-2:0], q_bit};
          hi_d     = q_bit ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
          equal_d  = eq_pend_q;
          dz_d     = 1'b0;
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mcand_q   <= {WIDTH{1'b0}};
      acc_hi_q  <= {WIDTH{1'b0}};
      acc_lo_q  <= {WIDTH{1'b0}};
      count_q   <= {CW{1'b0}};
      eq_pend_q <= 1'b0;
      result_q  <= {WIDTH{1'b0}};
      hi_q      <= {WIDTH{1'b0}};
      equal_q   <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      count_q   <= count_d;
      eq_pend_q <= eq_pend_d;
      result_q  <= result_d;
      hi_q      <= hi_d;
      equal_q   <= equal_d;
      dz_q      <= dz_d;
    end
  end

  assign result = result_q;
  assign hi     = hi_q;
  assign equal  = equal_q;
  assign dz     = dz_q;
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed, table-driven bench for multicycle_alu (32-bit instance plus an 8-bit instance).
module tb_multicycle_alu;

  logic        clk;
  logic        reset;

  logic        st32, busy32, done32, eq32, dz32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, res32, hi32;

  logic        st8, busy8, done8, eq8, dz8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, res8, hi8;

  int n_checks = 0;
  int n_err    = 0;

  multicycle_alu #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .start(st32), .op(op32), .a(a32), .b(b32),
    .result(res32), .hi(hi32), .equal(eq32), .busy(busy32), .done(done32), .dz(dz32)
  );

  multicycle_alu #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(st8), .op(op8), .a(a8), .b(b8),
    .result(res8), .hi(hi8), .equal(eq8), .busy(busy8), .done(done8), .dz(dz8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] hi;
    logic        eq;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one operation on the selected instance and wait (bounded) for done.
  task automatic run_op(input bit sel, input logic [2:0] op, input logic [31:0] av,
                        input logic [31:0] bv, output int lat, output logic [31:0] r,
                        output logic [31:0] h, output logic e, output logic z);
    @(negedge clk);
    if (sel) begin
      op8 = op; a8 = av[7:0]; b8 = bv[7:0]; st8 = 1'b1;
    end else begin
      op32 = op; a32 = av; b32 = bv; st32 = 1'b1;
    end
    @(posedge clk);
    #1;
    st8 = 1'b0;
    st32 = 1'b0;
    lat = 1;
    while (!(sel ? done8 : done32) && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r = sel ? {24'd0, res8} : res32;
    h = sel ? {24'd0, hi8} : hi32;
    e = sel ? eq8 : eq32;
    z = sel ? dz8 : dz32;
  endtask

  initial begin
    int          lat;
    int          cyc;
    bit          seen;
    logic [31:0] r, h;
    logic        e, z;

    vecs.push_back('{3'b000, 32'd9999, 32'd8111, 32'd18110, 32'd0, 1'b0, 1'b0, 1});
    vecs.push_back('{3'b001, 32'd9999, 32'd8111, 32'd1888, 32'd0, 1'b0, 1'b0, 1});
    vecs.push_back('{3'b001, 32'd8111, 32'd9999, 32'hFFFFF8A0, 32'd0, 1'b0, 1'b0, 1});
    vecs.push_back('{3'b000, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 1});
    vecs.push_back('{3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'd0, 1'b0, 1'b0, 1});
    vecs.push_back('{3'b011, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 32'd0, 1'b0, 1'b0, 1});
    vecs.push_back('{3'b101, 32'h0F0F0F0F, 32'hF0F00000, 32'h0000F0F0, 32'd0, 1'b0, 1'b0, 1});
    vecs.push_back('{3'b100, 32'd8111, 32'd8111, 32'd0, 32'd0, 1'b1, 1'b0, 1});
    vecs.push_back('{3'b100, 32'hFFFFFFFF, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 1});
    vecs.push_back('{3'b100, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0, 1'b0, 1});
    vecs.push_back('{3'b110, 32'd9999, 32'd8111, 32'd81101889, 32'd0, 1'b0, 1'b0, 33});
    vecs.push_back('{3'b110, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFE, 1'b1, 1'b0, 33});
    vecs.push_back('{3'b110, 32'h12345678, 32'h00000100, 32'h34567800, 32'h00000012, 1'b0, 1'b0, 33});
`ifdef MULTICYCLE_ALU_DIV_EN
    vecs.push_back('{3'b111, 32'd9999, 32'd8111, 32'd1, 32'd1888, 1'b0, 1'b0, 33});
    vecs.push_back('{3'b111, 32'd9999, 32'd0, 32'hFFFFFFFF, 32'd9999, 1'b0, 1'b1, 1});
    vecs.push_back('{3'b111, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 33});
    vecs.push_back('{3'b111, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF, 1'b0, 1'b0, 33});
`else
    vecs.push_back('{3'b111, 32'd9999, 32'd8111, 32'd0, 32'd0, 1'b0, 1'b0, 1});
    vecs.push_back('{3'b111, 32'd9999, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1});
`endif

    st32 = 1'b0; op32 = 3'b000; a32 = 32'd0; b32 = 32'd0;
    st8  = 1'b0; op8  = 3'b000; a8  = 8'd0;  b8  = 8'd0;
    reset = 1'b1;
    #1;
    chk("rst_result", {32'd0, res32}, 64'd0);
    chk("rst_hi",     {32'd0, hi32}, 64'd0);
    chk("rst_flags",  {60'd0, busy32, done32, eq32, dz32}, 64'd0);
    chk("rst8_out",   {44'd0, res8, hi8, busy8, done8, eq8, dz8}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, lat, r, h, e, z);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d_result", i), {32'd0, r}, {32'd0, vecs[i].res});
      chk($sformatf("v%0d_hi", i), {32'd0, h}, {32'd0, vecs[i].hi});
      chk($sformatf("v%0d_equal", i), {63'd0, e}, {63'd0, vecs[i].eq});
      chk($sformatf("v%0d_dz", i), {63'd0, z}, {63'd0, vecs[i].dz});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_1cyc", i), {62'd0, done32, busy32}, 64'd0);
      chk($sformatf("v%0d_hold", i), {32'd0, res32}, {32'd0, vecs[i].res});
    end

    // Start and operand changes during MULU must not disturb it.
    @(negedge clk);
    op32 = 3'b110; a32 = 32'd9999; b32 = 32'd8111; st32 = 1'b1;
    @(posedge clk);
    #1;
    st32 = 1'b0;
    lat = 1;
    while (!done32 && lat < 200) begin
      if (lat == 5) begin
        st32 = 1'b1; op32 = 3'b000; a32 = 32'd1; b32 = 32'd2;
      end else if (lat == 6) begin
        st32 = 1'b0; a32 = 32'hDEADBEEF; b32 = 32'hDEADBEEF; op32 = 3'b010;
      end
      @(posedge clk);
      #1;
      lat++;
      if (lat == 3) chk("busy_inflight", {63'd0, busy32}, 64'd1);
    end
    chk("ign_lat", 64'(lat), 64'd33);
    chk("ign_result", {32'd0, res32}, 64'd81101889);
    chk("ign_hi_eq", {31'd0, hi32, eq32}, 64'd0);
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done32) seen = 1'b1;
    end
    chk("ign_no_extra_done", {63'd0, seen}, 64'd0);

    // Reset mid-MULU with an ignored ADD start at cycle 5.
    @(negedge clk);
    op32 = 3'b110; a32 = 32'd9999; b32 = 32'd8111; st32 = 1'b1;
    @(posedge clk);
    #1;
    st32 = 1'b0;
    cyc = 1;
    seen = 1'b0;
    while (cyc < 10) begin
      if (cyc == 5) begin
        st32 = 1'b1; op32 = 3'b000;
      end else if (cyc == 6) begin
        st32 = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done32) seen = 1'b1;
      cyc++;
    end
    reset = 1'b1;
    #1;
    chk("abort_result", {32'd0, res32}, 64'd0);
    chk("abort_hi", {32'd0, hi32}, 64'd0);
    chk("abort_flags", {60'd0, busy32, done32, eq32, dz32}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done32) seen = 1'b1;
    end
    chk("abort_no_done", {63'd0, seen}, 64'd0);
    run_op(1'b0, 3'b000, 32'd9999, 32'd8111, lat, r, h, e, z);
    chk("post_rst_lat", 64'(lat), 64'd1);
    chk("post_rst_sum", {32'd0, r}, 64'd18110);

    // 8-bit instance.
    run_op(1'b1, 3'b110, 32'd200, 32'd3, lat, r, h, e, z);
    chk("w8_mul_lat", 64'(lat), 64'd9);
    chk("w8_mul_result", {32'd0, r}, 64'd88);
    chk("w8_mul_hi", {32'd0, h}, 64'd2);
    @(posedge clk);
    run_op(1'b1, 3'b000, 32'd200, 32'd100, lat, r, h, e, z);
    chk("w8_add_lat", 64'(lat), 64'd1);
    chk("w8_add_wrap", {32'd0, r}, 64'd44);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (legal 8..64).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request; sampled only when busy=0.
REQ-005 SHALL have port op  input  3  operation code (REQ-010).
REQ-006 SHALL have port a  input  WIDTH  operand A, captured with start.
REQ-007 SHALL have port b  input  WIDTH  operand B, captured with start.
REQ-008 SHALL have port result  output  WIDTH  low result / quotient.
REQ-009 SHALL have ports hi (output, WIDTH, product high half / remainder), equal (output, 1, captured a==b), busy (output, 1, operation in flight), done (output, 1, one-cycle completion pulse) and dz (output, 1, divide-by-zero flag).

Function
REQ-010 Op codes SHALL be: 000 ADD, 001 SUB (a-b), 010 AND, 011 OR, 100 SLT (signed, result 1/0), 101 NOR, 110 MULU, 111 DIVU.
REQ-011 States SHALL be IDLE, MUL, DIV, DONE; busy=1 in every state except IDLE.
REQ-012 In IDLE with start=1, the block SHALL capture a, b, op on that edge; start in any other state SHALL be ignored without side effects.
REQ-013 Ops 000-101 SHALL go IDLE->DONE on the capturing edge (result valid and done=1 the cycle after start).
REQ-014 MULU SHALL be unsigned shift-add, one bit per cycle: IDLE->MUL, WIDTH cycles in MUL, then DONE; done asserts WIDTH+1 cycles after the start edge.
REQ-015 MULU SHALL return the 2*WIDTH-bit product with {hi,result}.
REQ-016 DIVU SHALL be unsigned restoring division, one quotient bit per cycle, with identical timing to MULU; result=quotient, hi=remainder.
REQ-017 DIVU with b=0 SHALL go directly to DONE (latency 1), result all-ones, hi=a, dz=1.
REQ-018 dz SHALL be 0 for every other completed operation.
REQ-019 For ops 000-101 hi SHALL be 0; ADD/SUB SHALL wrap modulo 2^WIDTH with no overflow flag.
REQ-020 equal SHALL reflect captured a==b and update together with result.
REQ-021 DONE SHALL last exactly one cycle, then go to IDLE; result, hi, equal and dz SHALL hold until the next completion.
REQ-022 Minimum spacing between accepted starts SHALL be 2 cycles for single-cycle ops and WIDTH+2 for MULU/DIVU.
REQ-023 Changes on a, b or op while busy SHALL NOT affect the operation in flight.

Reset
REQ-024 reset SHALL asynchronously force state IDLE, busy=0, done=0, dz=0, equal=0, result=0, hi=0, and clear all internal iteration registers.
REQ-025 reset asserted mid-MULU/DIVU SHALL abort the operation with no done pulse; the first start after reset release SHALL be accepted normally.

Configuration
REQ-026 Macro MULTICYCLE_ALU_DIV_EN defined: DIVU SHALL be implemented as specified in REQ-016/017.
REQ-027 Macro MULTICYCLE_ALU_DIV_EN undefined: no divider logic; op 111 SHALL complete in 1 cycle with result=0, hi=0, dz=0.

Verification
REQ-028 WIDTH=32, a=9999, b=8111, ADD then SUB -> result 18110 then 1888, hi=0, equal=0, done one cycle after each start.
REQ-029 a=9999, b=8111, MULU -> done exactly 33 cycles after the start edge, result=81101889, hi=0; a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, result=1.
REQ-030 DIV_EN defined: a=9999, b=8111, DIVU -> 33-cycle latency, result=1, hi=1888, dz=0; b=0 -> 1-cycle latency, result=32'hFFFFFFFF, hi=9999, dz=1.
REQ-031 a=b=8111, SLT -> result 0, equal=1; a=-1 (32'hFFFFFFFF), b=1, SLT -> result 1, equal=0.
REQ-032 Start MULU, pulse start with op=ADD at cycle 5, assert reset at cycle 10 -> second start ignored, no done, all outputs 0; next ADD after release returns correct sum.
REQ-033 WIDTH=8 build, a=200, b=3, MULU -> 9-cycle latency, {hi,result}=600 (hi=2, result=88).
